// File: rtl/vga_screen_sequencer.sv
// rtl/vga_screen_sequencer.sv - selection index sequencer for the VGA pattern mux; timed auto-advance compiled in with SEQ_AUTO_EN
module vga_screen_sequencer #(
  parameter int                SEL_W     = 3,
  parameter int                STEP_W    = 4,
  parameter int                MIN_VAL   = 1,
  parameter int                MAX_VAL   = 4,
  parameter int                RESET_VAL = 0,
  parameter logic [STEP_W-1:0] ADV_CODE  = 4'b0011,
  parameter logic [STEP_W-1:0] BACK_CODE = 4'b0100,
  parameter int                WRAP      = 1,
  parameter int                PERIOD    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [SEL_W-1:0]  sel,
  output logic              adv_pulse,
  output logic              wrap_pulse
);

  typedef enum logic [1:0] {
    MANUAL   = 2'b00,
    AUTO_FWD = 2'b01,
    AUTO_REV = 2'b10,
    FREEZE   = 2'b11
  } mode_t;

  localparam logic [SEL_W-1:0] MIN_S   = SEL_W'(MIN_VAL);
  localparam logic [SEL_W-1:0] MAX_S   = SEL_W'(MAX_VAL);
  localparam logic [SEL_W-1:0] RESET_S = SEL_W'(RESET_VAL);

  // Reject parameter sets that would break the range arithmetic or the timer.
  if (PERIOD < 2 || MIN_VAL >= MAX_VAL || MAX_VAL >= (2 ** SEL_W)) begin : g_bad_params
    $error("vga_screen_sequencer: illegal parameter combination");
  end

  mode_t             mode_e;
  logic [STEP_W-1:0] step_q;
  logic              fwd_cmd;
  logic              back_cmd;
  logic              frozen;
  logic              do_fwd;
  logic              do_back;
  logic [SEL_W-1:0]  sel_nxt;
  logic              adv_nxt;
  logic              wrap_nxt;

  assign mode_e   = mode_t'(mode);
  assign frozen   = (mode_e == FREEZE);
  assign fwd_cmd  = (step == ADV_CODE)  && (step_q != ADV_CODE);
  assign back_cmd = (step == BACK_CODE) && (step_q != BACK_CODE);

  // Step history so a held code produces a single command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= '0;
    else     step_q <= step;
  end

`ifdef SEQ_AUTO_EN
  localparam int TW = $clog2(PERIOD);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_eff;
  logic [TW-1:0] timer_nxt;
  mode_t         mode_q;
  logic          auto_mode;
  logic          manual_cmd;
  logic          tick;

  // Timer and mode history; a mode change makes the current cycle count as timer value 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer  <= '0;
      mode_q <= MANUAL;
    end else begin
      timer  <= timer_nxt;
      mode_q <= mode_e;
    end
  end

  // Auto tick generation; a manual command wins over a coincident tick and restarts the interval.
  always_comb begin
    auto_mode  = (mode_e == AUTO_FWD) || (mode_e == AUTO_REV);
    manual_cmd = fwd_cmd || back_cmd;
    timer_eff  = (mode_e != mode_q) ? '0 : timer;
    tick       = auto_mode && (timer_eff == TW'(PERIOD - 1));
    timer_nxt  = timer_eff + TW'(1);
    if (!auto_mode || manual_cmd || tick) timer_nxt = '0;
    do_fwd  = !frozen && (fwd_cmd  || (tick && !manual_cmd && (mode_e == AUTO_FWD)));
    do_back = !frozen && (back_cmd || (tick && !manual_cmd && (mode_e == AUTO_REV)));
  end
`else
  // Without the timer, auto modes act as manual and only freeze gates commands.
  always_comb begin
    do_fwd  = !frozen && fwd_cmd;
    do_back = !frozen && back_cmd;
  end
`endif

  // Next index and pulse flags; out-of-range entry jumps to the range end without a wrap flag.
  always_comb begin
    sel_nxt  = sel;
    adv_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    if (do_fwd) begin
      if (sel < MIN_S || sel > MAX_S) begin
        sel_nxt = MIN_S;
        adv_nxt = 1'b1;
      end else if (sel < MAX_S) begin
        sel_nxt = sel + SEL_W'(1);
        adv_nxt = 1'b1;
      end else begin
        wrap_nxt = 1'b1;
        if (WRAP != 0) begin
          sel_nxt = MIN_S;
          adv_nxt = 1'b1;
        end
      end
    end else if (do_back) begin
      if (sel < MIN_S || sel > MAX_S) begin
        sel_nxt = MAX_S;
        adv_nxt = 1'b1;
      end else if (sel > MIN_S) begin
        sel_nxt = sel - SEL_W'(1);
        adv_nxt = 1'b1;
      end else begin
        wrap_nxt = 1'b1;
        if (WRAP != 0) begin
          sel_nxt = MAX_S;
          adv_nxt = 1'b1;
        end
      end
    end
  end

  // Registered index and single-cycle pulses aligned with the new index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= RESET_S;
      adv_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      sel        <= sel_nxt;
      adv_pulse  <= adv_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_vga_screen_sequencer.sv
// tb/tb_vga_screen_sequencer.sv - directed bench for vga_screen_sequencer (wrap and saturate instances)
module tb_vga_screen_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] step = 4'd0;
  logic [1:0] mode = 2'b00;
  logic [2:0] sel_w, sel_s;
  logic       adv_w, adv_s, wrap_w, wrap_s;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  vga_screen_sequencer dut_w (
    .clk(clk), .rst(rst), .step(step), .mode(mode),
    .sel(sel_w), .adv_pulse(adv_w), .wrap_pulse(wrap_w)
  );

  vga_screen_sequencer #(.WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .step(step), .mode(mode),
    .sel(sel_s), .adv_pulse(adv_s), .wrap_pulse(wrap_s)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    step = 4'd0;
    mode = 2'b00;
    edge1();
    rst  = 1'b0;
  endtask

  // One idle cycle, then the code for exactly one edge; outputs are sampled right after that edge.
  task automatic step_once(input logic [3:0] code);
    step = 4'd0;
    edge1();
    step = code;
    edge1();
    step = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({sel_w, adv_w, wrap_w} !== 5'b000_0_0) begin
      n_err++;
      $display("FAIL reset_wrap: got sel=%0d adv=%0b wrap=%0b, want sel=0 adv=0 wrap=0", sel_w, adv_w, wrap_w);
    end
    n_cmp++;
    if ({sel_s, adv_s, wrap_s} !== 5'b000_0_0) begin
      n_err++;
      $display("FAIL reset_sat: got sel=%0d adv=%0b wrap=%0b, want sel=0 adv=0 wrap=0", sel_s, adv_s, wrap_s);
    end
    do_reset();
  endtask

  task automatic test_held();
    do_reset();
    step = 4'b0011;
    edge1();
    n_cmp++;
    if ({sel_w, adv_w, wrap_w} !== 5'b001_1_0) begin
      n_err++;
      $display("FAIL held_first: got sel=%0d adv=%0b wrap=%0b, want sel=1 adv=1 wrap=0", sel_w, adv_w, wrap_w);
    end
    for (int k = 0; k < 9; k++) begin
      edge1();
      n_cmp++;
      if ({sel_w, adv_w} !== 4'b001_0) begin
        n_err++;
        $display("FAIL held_hold[%0d]: got sel=%0d adv=%0b, want sel=1 adv=0", k, sel_w, adv_w);
      end
    end
    step = 4'd0;
  endtask

  task automatic test_fwd_wrap();
    logic [2:0] exp_w [5];
    logic [2:0] exp_s [5];
    logic [4:0] exp_wrap;
    logic [4:0] exp_adv_s;
    exp_w     = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    exp_s     = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_wrap  = 5'b10000;
    exp_adv_s = 5'b01111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_once(4'b0011);
      n_cmp++;
      if ({sel_w, adv_w, wrap_w} !== {exp_w[i], 1'b1, exp_wrap[i]}) begin
        n_err++;
        $display("FAIL fwd_wrap[%0d]: got sel=%0d adv=%0b wrap=%0b, want sel=%0d adv=1 wrap=%0b",
                 i, sel_w, adv_w, wrap_w, exp_w[i], exp_wrap[i]);
      end
      n_cmp++;
      if ({sel_s, adv_s, wrap_s} !== {exp_s[i], exp_adv_s[i], exp_wrap[i]}) begin
        n_err++;
        $display("FAIL fwd_sat[%0d]: got sel=%0d adv=%0b wrap=%0b, want sel=%0d adv=%0b wrap=%0b",
                 i, sel_s, adv_s, wrap_s, exp_s[i], exp_adv_s[i], exp_wrap[i]);
      end
    end
    edge1();
    n_cmp++;
    if ({sel_w, adv_w, wrap_w} !== 5'b001_0_0) begin
      n_err++;
      $display("FAIL fwd_pulse_clear: got sel=%0d adv=%0b wrap=%0b, want sel=1 adv=0 wrap=0", sel_w, adv_w, wrap_w);
    end
  endtask

  task automatic test_rev_wrap();
    logic [2:0] exp_w [5];
    logic [2:0] exp_s [5];
    logic [4:0] exp_wrap;
    logic [4:0] exp_adv_s;
    exp_w     = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd4};
    exp_s     = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd1};
    exp_wrap  = 5'b10000;
    exp_adv_s = 5'b01111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_once(4'b0100);
      n_cmp++;
      if ({sel_w, adv_w, wrap_w} !== {exp_w[i], 1'b1, exp_wrap[i]}) begin
        n_err++;
        $display("FAIL rev_wrap[%0d]: got sel=%0d adv=%0b wrap=%0b, want sel=%0d adv=1 wrap=%0b",
                 i, sel_w, adv_w, wrap_w, exp_w[i], exp_wrap[i]);
      end
      n_cmp++;
      if ({sel_s, adv_s, wrap_s} !== {exp_s[i], exp_adv_s[i], exp_wrap[i]}) begin
        n_err++;
        $display("FAIL rev_sat[%0d]: got sel=%0d adv=%0b wrap=%0b, want sel=%0d adv=%0b wrap=%0b",
                 i, sel_s, adv_s, wrap_s, exp_s[i], exp_adv_s[i], exp_wrap[i]);
      end
    end
  endtask

  // Auto-forward: steps at edges 8 and 16, manual pulse on the terminal edge 24, next auto at 32.
  task automatic test_auto_fwd();
    logic [2:0] exp_sel;
    do_reset();
    mode = 2'b01;
    for (int k = 1; k <= 32; k++) begin
      if (k == 24) step = 4'b0011;
      edge1();
      step = 4'd0;
      if (k == 7 || k == 8 || k == 16 || k == 23 || k == 24 || k == 31 || k == 32) begin
`ifdef SEQ_AUTO_EN
        exp_sel = (k < 8) ? 3'd0 : (k < 16) ? 3'd1 : (k < 24) ? 3'd2 : (k < 32) ? 3'd3 : 3'd4;
`else
        exp_sel = (k < 24) ? 3'd0 : 3'd1;
`endif
        n_cmp++;
        if (sel_w !== exp_sel) begin
          n_err++;
          $display("FAIL auto_fwd_edge%0d: got sel=%0d, want sel=%0d", k, sel_w, exp_sel);
        end
      end
      if (k == 24) begin
        n_cmp++;
        if (adv_w !== 1'b1) begin
          n_err++;
          $display("FAIL auto_fwd_manual_adv: got adv=%0b, want adv=1", adv_w);
        end
      end
    end
  endtask

  task automatic test_freeze_then_rev();
    logic [2:0] exp_sel;
    do_reset();
    mode = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step = (k % 2 == 1) ? 4'b0011 : 4'b0100;
      edge1();
    end
    step = 4'd0;
    edge1();
    n_cmp++;
    if ({sel_w, adv_w} !== 4'b000_0) begin
      n_err++;
      $display("FAIL freeze_hold: got sel=%0d adv=%0b, want sel=0 adv=0", sel_w, adv_w);
    end
    mode = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      if (k >= 7) begin
`ifdef SEQ_AUTO_EN
        exp_sel = (k == 8) ? 3'd4 : 3'd0;
`else
        exp_sel = 3'd0;
`endif
        n_cmp++;
        if (sel_w !== exp_sel) begin
          n_err++;
          $display("FAIL freeze_to_rev_edge%0d: got sel=%0d, want sel=%0d", k, sel_w, exp_sel);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2:0] exp_sel;
    do_reset();
    mode = 2'b01;
    for (int k = 1; k <= 24; k++) edge1();
`ifdef SEQ_AUTO_EN
    exp_sel = 3'd3;
`else
    exp_sel = 3'd0;
`endif
    n_cmp++;
    if (sel_w !== exp_sel) begin
      n_err++;
      $display("FAIL midrun_before: got sel=%0d, want sel=%0d", sel_w, exp_sel);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({sel_w, adv_w, wrap_w} !== 5'b000_0_0) begin
      n_err++;
      $display("FAIL midrun_async_rst: got sel=%0d adv=%0b wrap=%0b, want sel=0 adv=0 wrap=0", sel_w, adv_w, wrap_w);
    end
    edge1();
    rst  = 1'b0;
    mode = 2'b00;
    step_once(4'b0011);
    n_cmp++;
    if ({sel_w, adv_w, wrap_w} !== 5'b001_1_0) begin
      n_err++;
      $display("FAIL midrun_after_rst: got sel=%0d adv=%0b wrap=%0b, want sel=1 adv=1 wrap=0", sel_w, adv_w, wrap_w);
    end
  endtask

  initial begin
    test_reset();
    test_held();
    test_fwd_wrap();
    test_rev_wrap();
    test_auto_fwd();
    test_freeze_then_rev();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
